trng_collector: RTL and testbench



---
 rtl/trng_collector.sv | 173 +++++++++++++++++
 tb/tb_trng_collector.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_collector.sv
// Von Neumann debiasing collector for a ring-oscillator entropy source. It packs the debiased bits into words behind a valid/ready handshake.
// Optional repetition-count health test enabled by defining TRNG_REPCNT_EN.
module trng_collector #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned REP_LIMIT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              ro_en,
  input  logic [SIZE-1:0]   raw_in,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [CNT_W-1:0]  discard_cnt,
  output logic              health_fail
);

  localparam int unsigned BIT_W = $clog2(WORD_W);
  localparam int unsigned SET_W = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, COLLECT, HOLD} state_t;

  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             have_first;
  logic             first_bit;
  logic             fold_c;

  assign fold_c = ^raw_in;

`ifdef TRNG_REPCNT_EN
  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             last_f;
  logic             low_seen;
  logic             rep_hit_c;

  // The sample that would extend the current run to REP_LIMIT trips the test.
  assign rep_hit_c = (rep_cnt != '0) && (fold_c == last_f) &&
                     (rep_cnt == REP_W'(REP_LIMIT - 1));
`else
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ro_en       <= 1'b0;
      rnd_data    <= '0;
      rnd_valid   <= 1'b0;
      discard_cnt <= '0;
      settle_cnt  <= '0;
      bit_cnt     <= '0;
      have_first  <= 1'b0;
      first_bit   <= 1'b0;
`ifdef TRNG_REPCNT_EN
      rep_cnt     <= '0;
      last_f      <= 1'b0;
      low_seen    <= 1'b0;
      health_fail <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ro_en <= 1'b0;
`ifdef TRNG_REPCNT_EN
          // After a failure, a fresh run rising edge is required to restart.
          if (health_fail) begin
            if (!run) begin
              low_seen <= 1'b1;
            end else if (low_seen) begin
              health_fail <= 1'b0;
              low_seen    <= 1'b0;
              state       <= SETTLE;
              settle_cnt  <= '0;
              ro_en       <= 1'b1;
            end
          end else if (run) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            ro_en      <= 1'b1;
          end
`else
          if (run) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            ro_en      <= 1'b1;
          end
`endif
        end

        SETTLE: begin
`ifdef TRNG_REPCNT_EN
          rep_cnt <= '0;
`endif
          if (!run) begin
            state <= IDLE;
            ro_en <= 1'b0;
          end else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
            state <= COLLECT;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        COLLECT: begin
          if (!run) begin
            state      <= IDLE;
            ro_en      <= 1'b0;
            have_first <= 1'b0;
            bit_cnt    <= '0;
          end else begin
            if (!have_first) begin
              first_bit  <= fold_c;
              have_first <= 1'b1;
            end else begin
              have_first <= 1'b0;
              if (fold_c != first_bit) begin
                rnd_data <= {first_bit, rnd_data[WORD_W-1:1]};
                if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                  state     <= HOLD;
                  rnd_valid <= 1'b1;
                  bit_cnt   <= '0;
                end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                end
              end else if (discard_cnt != '1) begin
                discard_cnt <= discard_cnt + CNT_W'(1);
              end
            end
`ifdef TRNG_REPCNT_EN
            last_f  <= fold_c;
            rep_cnt <= ((rep_cnt != '0) && (fold_c == last_f)) ?
                       rep_cnt + REP_W'(1) : REP_W'(1);
            if (rep_hit_c) begin
              health_fail <= 1'b1;
              low_seen    <= 1'b0;
              state       <= IDLE;
              ro_en       <= 1'b0;
              rnd_valid   <= 1'b0;
              have_first  <= 1'b0;
              bit_cnt     <= '0;
            end
`endif
          end
        end

        HOLD: begin
          // Word is only released by a handshake, even if run has dropped.
          if (rnd_ready) begin
            rnd_valid  <= 1'b0;
            have_first <= 1'b0;
            bit_cnt    <= '0;
            state      <= run ? COLLECT : IDLE;
            ro_en      <= run;
          end
        end

        default: begin
          state <= IDLE;
          ro_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Self-checking bench for trng_collector: a word-level reference model is compared against the DUT on every cycle.
module tb_trng_collector;

  localparam int unsigned SIZE       = 8;
  localparam int unsigned WORD_W     = 8;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned REP_LIMIT  = 16;
  localparam int CNT_MAX = 15;

  localparam int P_IDLE = 0, P_SETTLE = 1, P_COLLECT = 2, P_HOLD = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              ro_en;
  logic [SIZE-1:0]   raw_in = '0;
  logic [WORD_W-1:0] rnd_data;
  logic              rnd_valid;
  logic              rnd_ready = 1'b0;
  logic [CNT_W-1:0]  discard_cnt;
  logic              health_fail;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;

  trng_collector #(
    .SIZE(SIZE), .WORD_W(WORD_W), .SETTLE_CYC(SETTLE_CYC),
    .CNT_W(CNT_W), .REP_LIMIT(REP_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .ro_en(ro_en), .raw_in(raw_in),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .discard_cnt(discard_cnt), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         phase;
    int         settle_left;
    bit         have_first;
    bit         first;
    int         nbits;
    logic [7:0] acc;
    logic [7:0] word;
    bit         valid;
    bit         ro;
    int         disc;
    bit         hf;
    bit         armed;
    int         run_len;
    bit         last_f;
  } model_t;

  model_t m = '{default: 0};

  // Reference behaviour over one clock edge, written from the collector's rules.
  function automatic model_t step(model_t cur, logic r, logic rn, logic rdy, logic [7:0] raw);
    model_t n;
    bit f;
    n = cur;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    f = ^raw;
    case (cur.phase)
      P_IDLE: begin
        n.ro = 1'b0;
        if (cur.hf) begin
          if (!rn) n.armed = 1'b1;
          else if (cur.armed) begin
            n.hf = 1'b0; n.armed = 1'b0; n.phase = P_SETTLE;
            n.settle_left = SETTLE_CYC; n.ro = 1'b1; n.run_len = 0;
          end
        end else if (rn) begin
          n.phase = P_SETTLE; n.settle_left = SETTLE_CYC; n.ro = 1'b1; n.run_len = 0;
        end
      end
      P_SETTLE: begin
        if (!rn) begin
          n.phase = P_IDLE; n.ro = 1'b0;
        end else begin
          n.settle_left = cur.settle_left - 1;
          if (n.settle_left == 0) n.phase = P_COLLECT;
        end
      end
      P_COLLECT: begin
        if (!rn) begin
          n.phase = P_IDLE; n.ro = 1'b0; n.have_first = 1'b0; n.nbits = 0; n.acc = '0;
        end else begin
          if (!cur.have_first) begin
            n.have_first = 1'b1; n.first = f;
          end else begin
            n.have_first = 1'b0;
            if (f != cur.first) begin
              n.acc = cur.acc | (8'(cur.first) << cur.nbits);
              n.nbits = cur.nbits + 1;
              if (n.nbits == WORD_W) begin
                n.word = n.acc; n.acc = '0; n.nbits = 0;
                n.valid = 1'b1; n.phase = P_HOLD;
              end
            end else begin
              n.disc = (cur.disc < CNT_MAX) ? cur.disc + 1 : CNT_MAX;
            end
          end
`ifdef TRNG_REPCNT_EN
          n.run_len = (cur.run_len > 0 && f == cur.last_f) ? cur.run_len + 1 : 1;
          n.last_f = f;
          if (n.run_len >= REP_LIMIT) begin
            n.hf = 1'b1; n.armed = 1'b0; n.phase = P_IDLE; n.ro = 1'b0;
            n.valid = 1'b0; n.have_first = 1'b0; n.nbits = 0; n.acc = '0;
          end
`endif
        end
      end
      P_HOLD: begin
        if (rdy) begin
          n.valid = 1'b0; n.have_first = 1'b0;
          n.phase = rn ? P_COLLECT : P_IDLE; n.ro = rn;
        end
      end
      default: n.phase = P_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst, run, rnd_ready, raw_in);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("ro_en", 32'(ro_en), 32'(m.ro));
      chk("rnd_valid", 32'(rnd_valid), 32'(m.valid));
      if (m.valid) chk("rnd_data", 32'(rnd_data), 32'(m.word));
      chk("discard_cnt", 32'(discard_cnt), 32'(m.disc));
      chk("health_fail", 32'(health_fail), 32'(m.hf));
    end
  end

  function automatic logic [7:0] raw_par(input bit b);
    logic [7:0] v;
    v = 8'($urandom);
    if ((^v) != b) v[0] = ~v[0];
    return v;
  endfunction

  task automatic tick(input logic r, input logic rn, input logic rdy, input logic [7:0] raw);
    rst = r; run = rn; rnd_ready = rdy; raw_in = raw;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit s_word[16]  = '{1,0, 0,1, 1,0, 1,0, 0,1, 0,1, 1,0, 0,1};
  bit s_abort[6]  = '{1,0, 0,1, 1,0};
  bit s_word2[16] = '{0,1, 0,1, 0,1, 0,1, 1,0, 1,0, 1,0, 1,0};

  initial begin
    // Reset with run held high.
    tick(1'b1, 1'b1, 1'b0, 8'($urandom));
    checking = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 8'($urandom));
    chk("reset ro_en", 32'(ro_en), 32'h0);
    chk("reset rnd_valid", 32'(rnd_valid), 32'h0);
    chk("reset rnd_data", 32'(rnd_data), 32'h0);
    chk("reset discard_cnt", 32'(discard_cnt), 32'h0);
    chk("reset health_fail", 32'(health_fail), 32'h0);

    // Word build: start edge, settle samples, then 8 pairs.
    tick(1'b0, 1'b1, 1'b0, 8'($urandom));
    chk("settle ro_en", 32'(ro_en), 32'h1);
    for (int i = 0; i < int'(SETTLE_CYC); i++) tick(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("no early valid", 32'(rnd_valid), 32'h0);
      tick(1'b0, 1'b1, 1'b0, raw_par(s_word[i]));
    end
    chk("word valid", 32'(rnd_valid), 32'h1);
    chk("word data", 32'(rnd_data), 32'h4D);
    chk("word discard_cnt", 32'(discard_cnt), 32'h0);

    // Backpressure then a single-cycle handshake.
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 8'($urandom));
    chk("hold data", 32'(rnd_data), 32'h4D);
    chk("hold valid", 32'(rnd_valid), 32'h1);
    chk("hold discard_cnt", 32'(discard_cnt), 32'h0);
    tick(1'b0, 1'b1, 1'b1, 8'($urandom));
    chk("handshake valid", 32'(rnd_valid), 32'h0);

    // Discards: equal pairs 00/11 saturate the counter.
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b0, raw_par(((i / 2) % 2) == 1));
    chk("discard saturate", 32'(discard_cnt), 32'hF);
    chk("discard no word", 32'(rnd_valid), 32'h0);

    // Abort after 3 emitted bits, restart, new word must hold no old bits.
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, raw_par(s_abort[i]));
    tick(1'b0, 1'b0, 1'b0, 8'($urandom));
    chk("abort ro_en", 32'(ro_en), 32'h0);
    tick(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < int'(SETTLE_CYC); i++) tick(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b0, raw_par(s_word2[i]));
    chk("restart valid", 32'(rnd_valid), 32'h1);
    chk("restart data", 32'(rnd_data), 32'hF0);
    tick(1'b0, 1'b0, 1'b1, 8'($urandom));
    chk("release to idle ro_en", 32'(ro_en), 32'h0);

    // Randomized traffic with occasional reset and run drops.
    for (int i = 0; i < 4000; i++)
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 97,
           1'($urandom_range(0, 1)), 8'($urandom));

`ifdef TRNG_REPCNT_EN
    // Health test: a constant folded stream trips after REP_LIMIT samples.
    tick(1'b1, 1'b1, 1'b0, 8'($urandom));
    tick(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < int'(SETTLE_CYC); i++) tick(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < int'(REP_LIMIT) - 1; i++) tick(1'b0, 1'b1, 1'b0, 8'h00);
    chk("health below limit", 32'(health_fail), 32'h0);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    chk("health trip", 32'(health_fail), 32'h1);
    chk("health ro_en", 32'(ro_en), 32'h0);
    chk("health valid", 32'(rnd_valid), 32'h0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 8'($urandom));
    chk("health sticky", 32'(health_fail), 32'h1);
    chk("health sticky ro_en", 32'(ro_en), 32'h0);
    tick(1'b0, 1'b0, 1'b0, 8'($urandom));
    chk("health run low", 32'(health_fail), 32'h1);
    tick(1'b0, 1'b1, 1'b0, 8'($urandom));
    chk("health cleared", 32'(health_fail), 32'h0);
    chk("health resettle ro_en", 32'(ro_en), 32'h1);
`endif

    tick(1'b0, 1'b0, 1'b1, 8'($urandom));
    tick(1'b0, 1'b0, 1'b1, 8'($urandom));
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
